register_array_mp: RTL

REGISTER_ARRAY_MP -- requirements
Module: register_array_mp

---
 rtl/register_array_mp_pkg.sv | 12 +
 rtl/regfile_rdport.sv | 36 +++
 rtl/register_array_mp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/register_array_mp_pkg.sv
// rtl/register_array_mp_pkg.sv - shared types and default sizing for the register array
package register_array_mp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read port: entry mux, same-cycle write bypass, busy gating
module regfile_rdport
    import register_array_mp_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic               init_done_i,
    input  logic               re_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [NREG*XLEN-1:0] entries_i,
    input  logic [NREG-1:0]    busy_i,
    input  logic               wen_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [XLEN-1:0]    wdata_i,
    output logic [XLEN-1:0]    data_o,
    output logic               busy_o
);

    always_comb begin
        data_o = '0;
        busy_o = 1'b0;
        if (init_done_i && re_i && (addr_i != '0)) begin
            // A writeback landing this cycle both supplies the data and retires the producer
            if (wen_i && (waddr_i == addr_i)) begin
                data_o = wdata_i;
                busy_o = 1'b0;
            end else begin
                data_o = entries_i[int'(addr_i)*XLEN +: XLEN];
                busy_o = busy_i[addr_i];
            end
        end
    end

endmodule

// File: rtl/register_array_mp.sv
// rtl/register_array_mp.sv - multi-read-port register array with busy scoreboard and clear sweep
module register_array_mp
    import register_array_mp_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RegWEn,
    input  logic [AW-1:0]       AddrD,
    input  logic [XLEN-1:0]     DataD,
    input  logic                IssueEn,
    input  logic [AW-1:0]       IssueAddr,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   AddrR,
    output logic [NRD*XLEN-1:0] DataR,
    output logic [NRD-1:0]      BusyR,
    output logic                init_done
);

    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            init_done_q;
    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG*XLEN-1:0] mem_flat;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_en;
    logic            iss_en;

    assign wr_en  = init_done_q && RegWEn  && (AddrD     != '0);
    assign iss_en = init_done_q && IssueEn && (IssueAddr != '0);
    assign init_done = init_done_q;

    // Entry 0 is hardwired, so the sweep starts at 1 and ends on the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= AW'(1);
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + AW'(1);
                    if (clr_cnt_q == AW'(NREG - 1)) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_q     <= ST_READY;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_CLEAR;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset; the sweep above is what zeroes it
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[AddrD] <= DataD;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        if (g == 0) begin : g_zero
            assign mem_flat[g*XLEN +: XLEN] = '0;
        end else begin : g_entry
            assign mem_flat[g*XLEN +: XLEN] = mem_q[g];
        end
    end

    // Set is applied after clear so a re-issue in the writeback cycle keeps the bit
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[AddrD] = 1'b0;
        end
        if (iss_en) begin
            busy_d[IssueAddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rdport #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
        ) u_rdport (
            .init_done_i (init_done_q),
            .re_i        (re[p]),
            .addr_i      (AddrR[p*AW +: AW]),
            .entries_i   (mem_flat),
            .busy_i      (busy_q),
            .wen_i       (RegWEn),
            .waddr_i     (AddrD),
            .wdata_i     (DataD),
            .data_o      (DataR[p*XLEN +: XLEN]),
            .busy_o      (BusyR[p])
        );
    end

endmodule
